// File: rtl/armleo_weighted_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : armleo_weighted_rr_arbiter
//  Description : Registered weighted round-robin arbiter. Each requester keeps
//                the grant for up to weight[i] acks; lock extends the grant
//                without spending credit. Back-to-back grants need no bubble.
//  Revision    : 1.0 - initial release
// ============================================================================
module armleo_weighted_rr_arbiter #(
  parameter int WIDTH    = 4,
  parameter int WEIGHT_W = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          request_i,
  input  logic [WIDTH*WEIGHT_W-1:0] weight_i,
  input  logic                      lock_i,
  input  logic                      ack_i,
  output logic                      grant_vld_o,
  output logic [WIDTH-1:0]          grant_o,
  output logic [$clog2(WIDTH)-1:0]  grant_idx_o
);

  localparam int IDX_W = $clog2(WIDTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]          state_q,     state_d;
  logic [IDX_W-1:0]    pointer_q,   pointer_d;
  logic [WEIGHT_W-1:0] credit_q,    credit_d;
  logic                grant_vld_q, grant_vld_d;
  logic [WIDTH-1:0]    grant_q,     grant_d;
  logic [IDX_W-1:0]    grant_idx_q, grant_idx_d;

  logic [IDX_W-1:0]    next_ptr;
  logic [IDX_W-1:0]    base_ptr;
  logic                win_found;
  logic [IDX_W-1:0]    win_idx;
  logic [WEIGHT_W-1:0] win_weight;
  logic [WEIGHT_W-1:0] win_weff;

  // Pointer that follows the current holder, wrapping back to requester 0.
  assign next_ptr = (grant_idx_q == IDX_W'(WIDTH - 1)) ? '0 : grant_idx_q + IDX_W'(1);

  // While BUSY the only arbitration that matters is the release-with-ack one,
  // which must already see the advanced pointer in the same cycle.
  assign base_ptr = (state_q == ST_BUSY) ? next_ptr : pointer_q;

  // Rotating priority search: first asserted request starting at base_ptr.
  always_comb begin
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    sum       = '0;
    cand      = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum = {1'b0, base_ptr} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(WIDTH)) begin
        sum = sum - (IDX_W+1)'(WIDTH);
      end
      cand = sum[IDX_W-1:0];
      if (!win_found && request_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // A zero weight still entitles the winner to one transfer.
  assign win_weight = weight_i[win_idx*WEIGHT_W +: WEIGHT_W];
  assign win_weff   = (win_weight == '0) ? WEIGHT_W'(1) : win_weight;

  // Next-state logic for grant, credit and pointer.
  always_comb begin
    state_d     = state_q;
    pointer_d   = pointer_q;
    credit_d    = credit_q;
    grant_vld_d = grant_vld_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d          = ST_BUSY;
          grant_vld_d      = 1'b1;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          grant_idx_d      = win_idx;
          credit_d         = win_weff;
        end
      end
      default: begin
        if (!ack_i) begin
          // Holder abandoned its request mid-burst: drop the grant, no re-arbitration.
          if (!request_i[grant_idx_q]) begin
            state_d     = ST_IDLE;
            pointer_d   = next_ptr;
            credit_d    = '0;
            grant_vld_d = 1'b0;
            grant_d     = '0;
            grant_idx_d = '0;
          end
        end else if (lock_i) begin
          // Locked transfer: hold the grant and keep the remaining credit.
        end else if (credit_q > WEIGHT_W'(1) && request_i[grant_idx_q]) begin
          credit_d = credit_q - WEIGHT_W'(1);
        end else begin
          pointer_d = next_ptr;
          if (win_found) begin
            grant_d          = '0;
            grant_d[win_idx] = 1'b1;
            grant_idx_d      = win_idx;
            credit_d         = win_weff;
          end else begin
            state_d     = ST_IDLE;
            credit_d    = '0;
            grant_vld_d = 1'b0;
            grant_d     = '0;
            grant_idx_d = '0;
          end
        end
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pointer_q   <= '0;
      credit_q    <= '0;
      grant_vld_q <= 1'b0;
      grant_q     <= '0;
      grant_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      pointer_q   <= pointer_d;
      credit_q    <= credit_d;
      grant_vld_q <= grant_vld_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
    end
  end

  assign grant_vld_o = grant_vld_q;
  assign grant_o     = grant_q;
  assign grant_idx_o = grant_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_armleo_weighted_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_armleo_weighted_rr_arbiter
//  Description : Directed scenarios plus randomized traffic for the weighted
//                round-robin arbiter, checked against an integer-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_armleo_weighted_rr_arbiter;

  localparam int W  = 4;
  localparam int WW = 4;

  logic          clk;
  logic          rst;
  logic [W-1:0]  request;
  logic [W*WW-1:0] weight;
  logic          lock;
  logic          ack;
  logic          grant_vld;
  logic [W-1:0]  grant;
  logic [1:0]    grant_idx;

  int checks = 0;
  int errors = 0;

  // Reference model: who holds the grant (-1 = nobody), transfers left, start of search.
  int m_holder = -1;
  int m_credit = 0;
  int m_ptr    = 0;

  armleo_weighted_rr_arbiter #(.WIDTH(W), .WEIGHT_W(WW)) dut (
    .clk         (clk),
    .rst         (rst),
    .request_i   (request),
    .weight_i    (weight),
    .lock_i      (lock),
    .ack_i       (ack),
    .grant_vld_o (grant_vld),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int weff_of(input logic [W*WW-1:0] wv, input int i);
    int v;
    v = int'((wv >> (WW * i)) & 16'hF);
    return (v == 0) ? 1 : v;
  endfunction

  // Give the grant to the first requester at or after 'from', wrapping around.
  task automatic model_pick(input logic [W-1:0] req, input logic [W*WW-1:0] wv, input int from);
    m_holder = -1;
    m_credit = 0;
    for (int k = 0; k < W; k++) begin
      int c;
      c = (from + k) % W;
      if (m_holder < 0 && req[c]) begin
        m_holder = c;
        m_credit = weff_of(wv, c);
      end
    end
  endtask

  task automatic model_advance(input logic [W-1:0] req, input logic [W*WW-1:0] wv,
                               input logic lk, input logic ak);
    if (m_holder < 0) begin
      model_pick(req, wv, m_ptr);
    end else if (!ak) begin
      if (!req[m_holder]) begin
        m_ptr    = (m_holder + 1) % W;
        m_holder = -1;
        m_credit = 0;
      end
    end else if (lk) begin
      // credit is not spent on a locked transfer
    end else if (m_credit > 1 && req[m_holder]) begin
      m_credit = m_credit - 1;
    end else begin
      m_ptr = (m_holder + 1) % W;
      model_pick(req, wv, m_ptr);
    end
  endtask

  task automatic model_reset();
    m_holder = -1;
    m_credit = 0;
    m_ptr    = 0;
  endtask

  task automatic check_outputs(input string tag);
    logic         e_vld;
    logic [W-1:0] e_grant;
    logic [1:0]   e_idx;
    e_vld   = (m_holder >= 0);
    e_grant = (m_holder >= 0) ? (W'(1) << m_holder) : '0;
    e_idx   = (m_holder >= 0) ? 2'(m_holder) : 2'd0;
    checks++;
    assert (grant_vld === e_vld) else begin
      errors++;
      $error("FAIL %s grant_vld: observed %0b expected %0b", tag, grant_vld, e_vld);
    end
    checks++;
    assert (grant === e_grant) else begin
      errors++;
      $error("FAIL %s grant: observed %b expected %b", tag, grant, e_grant);
    end
    checks++;
    assert (grant_idx === e_idx) else begin
      errors++;
      $error("FAIL %s grant_idx: observed %0d expected %0d", tag, grant_idx, e_idx);
    end
  endtask

  task automatic check_idx(input string tag, input int exp_idx);
    checks++;
    assert (grant_vld === 1'b1 && int'(grant_idx) == exp_idx) else begin
      errors++;
      $error("FAIL %s: observed vld=%0b idx=%0d expected vld=1 idx=%0d", tag, grant_vld, grant_idx, exp_idx);
    end
  endtask

  // One clock: drive inputs, advance the model, sample 1 ns after the edge.
  task automatic step(input string tag, input logic [W-1:0] req, input logic [W*WW-1:0] wv,
                      input logic lk, input logic ak);
    request = req;
    weight  = wv;
    lock    = lk;
    ack     = ak;
    model_advance(req, wv, lk, ak);
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    request = '0;
    lock    = 1'b0;
    ack     = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_outputs("reset");
  endtask

  initial begin
    int exp_seq1 [5];
    int exp_seq2 [8];
    logic [W-1:0]    r_req;
    logic [W*WW-1:0] r_wt;

    rst     = 1'b1;
    request = '0;
    weight  = '0;
    lock    = 1'b0;
    ack     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset_initial");
    rst = 1'b0;

    // Scenario 1: equal weights, full request, ack every cycle.
    exp_seq1 = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin
      step("s1", 4'b1111, 16'h1111, 1'b0, 1'b1);
      check_idx("s1_seq", exp_seq1[k]);
    end
    step("s1_drain", 4'b0000, 16'h1111, 1'b0, 1'b1);

    // Scenario 2: requester 0 has weight 3.
    do_reset();
    exp_seq2 = '{0, 0, 0, 1, 0, 0, 0, 1};
    for (int k = 0; k < 8; k++) begin
      step("s2", 4'b0011, 16'h1113, 1'b0, 1'b1);
      check_idx("s2_seq", exp_seq2[k]);
    end

    // Scenario 3: locked burst on requester 2.
    do_reset();
    step("s3_grant", 4'b0100, 16'h1111, 1'b0, 1'b0);
    check_idx("s3_grant", 2);
    for (int k = 0; k < 5; k++) begin
      step("s3_lock", 4'b1111, 16'h1111, 1'b1, 1'b1);
      check_idx("s3_lock", 2);
    end
    step("s3_release", 4'b1111, 16'h1111, 1'b0, 1'b1);
    check_idx("s3_next", 3);

    // Scenario 4: abort when the holder drops its request without ack.
    do_reset();
    step("s4_grant", 4'b0010, 16'h1111, 1'b0, 1'b0);
    check_idx("s4_grant", 1);
    step("s4_abort", 4'b1101, 16'h1111, 1'b1, 1'b0);
    step("s4_regrant", 4'b1111, 16'h1111, 1'b0, 1'b0);
    check_idx("s4_regrant", 2);

    // Scenario 5: zero weight, sole requester re-wins, then idle.
    do_reset();
    step("s5_grant", 4'b1000, 16'h0000, 1'b0, 1'b0);
    step("s5_rewin", 4'b1000, 16'h0000, 1'b0, 1'b1);
    check_idx("s5_rewin", 3);
    step("s5_idle", 4'b0000, 16'h0000, 1'b0, 1'b1);

    // Scenario 6: asynchronous reset in the middle of a burst.
    do_reset();
    step("s6_grant", 4'b0001, 16'h1113, 1'b0, 1'b0);
    step("s6_ack", 4'b0001, 16'h1113, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs("s6_async_rst");
    #1;
    rst = 1'b0;
    step("s6_after", 4'b1010, 16'h1113, 1'b0, 1'b0);
    check_idx("s6_after", 1);

    // Randomized traffic; the holder usually keeps its request up.
    do_reset();
    r_wt = 16'($urandom);
    for (int k = 0; k < 400; k++) begin
      r_req = 4'($urandom);
      if (m_holder >= 0 && ($urandom_range(0, 9) != 0)) begin
        r_req[m_holder] = 1'b1;
      end
      if ($urandom_range(0, 7) == 0) begin
        r_wt = 16'($urandom);
      end
      step("rand", r_req, r_wt, ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
